// File: rtl/pipe_pkg.sv
// Shared definitions for the PC sequencing controller: FSM encoding,
// register-file constants and the NOP word used when IF/ID is flushed.
package pipe_pkg;

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    WAIT       = 2'd1,
    WAIT_REDIR = 2'd2
  } pc_state_t;

  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; holds at all-ones.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             i_clk,
  input  logic             i_clearN,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge i_clk) begin
    if (!i_clearN) begin
      r_count <= '0;
    end else if (i_en && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/pc_control.sv
// PC / IF-ID sequencing controller: load-use stalls, slow-imem waits and
// deferred redirects that are replayed once the fetch completes.
module pc_control
  import pipe_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imemReady,
  input  logic [ADDR_W-1:0] pcPlus4,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  input  logic              jump,
  input  logic [ADDR_W-1:0] jumpTarget,
  input  logic              idExMemRead,
  input  logic [4:0]        idExRt,
  input  logic [4:0]        ifIdRs,
  input  logic [4:0]        ifIdRt,
  output logic              pcWrite,
  output logic [ADDR_W-1:0] pcNext,
  output logic              ifIdWrite,
  output logic              ifIdFlush,
  output logic              idExBubble,
  output logic [CNT_W-1:0]  stallCnt,
  output logic [CNT_W-1:0]  flushCnt
);

  pc_state_t         r_state;
  pc_state_t         w_stateNext;
  logic [ADDR_W-1:0] r_pendTarget;
  logic              w_hazard;
  logic              w_redir;
  logic [ADDR_W-1:0] w_redirTarget;
  logic              w_redirLoad;
  logic              w_pendLoad;

  assign w_hazard = idExMemRead && (idExRt != REG_ZERO) &&
                    ((idExRt == ifIdRs) || (idExRt == ifIdRt));
  assign w_redir       = !w_hazard && (jump || branchTaken);
  assign w_redirTarget = jump ? jumpTarget : branchTarget;

  always_comb begin
    pcWrite     = 1'b0;
    pcNext      = pcPlus4;
    ifIdWrite   = 1'b1;
    ifIdFlush   = 1'b0;
    idExBubble  = 1'b0;
    w_stateNext = r_state;
    w_redirLoad = 1'b0;
    w_pendLoad  = 1'b0;

    if (!reset) begin
      ifIdWrite   = 1'b0;
      ifIdFlush   = 1'b1;
      idExBubble  = 1'b1;
      w_stateNext = RUN;
    end else if (w_hazard) begin
      // Branch/jump in ID is simply re-evaluated once the load has moved on.
      idExBubble = 1'b1;
      ifIdWrite  = 1'b0;
      if ((r_state == RUN) && !imemReady) w_stateNext = WAIT;
    end else begin
      unique case (r_state)
        RUN, WAIT: begin
          if (imemReady) begin
            pcWrite     = 1'b1;
            w_stateNext = RUN;
            if (w_redir) begin
              pcNext      = w_redirTarget;
              ifIdFlush   = 1'b1;
              w_redirLoad = 1'b1;
            end
          end else begin
            ifIdFlush = 1'b1;
            if (w_redir) begin
              w_pendLoad  = 1'b1;
              w_stateNext = WAIT_REDIR;
            end else begin
              w_stateNext = WAIT;
            end
          end
        end
        WAIT_REDIR: begin
          // The word arriving now is wrong-path, so it is flushed as well.
          ifIdFlush = 1'b1;
          if (imemReady) begin
            pcWrite     = 1'b1;
            pcNext      = r_pendTarget;
            w_redirLoad = 1'b1;
            w_stateNext = RUN;
          end
        end
        default: w_stateNext = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state      <= RUN;
      r_pendTarget <= '0;
    end else begin
      r_state <= w_stateNext;
      if (w_pendLoad) r_pendTarget <= w_redirTarget;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stallCnt (
    .i_clk    (clk),
    .i_clearN (reset),
    .i_en     (w_hazard || !pcWrite),
    .o_count  (stallCnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flushCnt (
    .i_clk    (clk),
    .i_clearN (reset),
    .i_en     (w_redirLoad),
    .o_count  (flushCnt)
  );

endmodule

// File: tb/tb_pc_control.sv
// Self-checking bench for pc_control: directed scenarios plus random traffic
// compared against a pending-redirect reference model.
module tb_pc_control;

  logic        clk = 1'b0;
  logic        reset;
  logic        imemReady;
  logic [31:0] pcPlus4;
  logic        branchTaken;
  logic [31:0] branchTarget;
  logic        jump;
  logic [31:0] jumpTarget;
  logic        idExMemRead;
  logic [4:0]  idExRt;
  logic [4:0]  ifIdRs;
  logic [4:0]  ifIdRt;
  logic        pcWrite;
  logic [31:0] pcNext;
  logic        ifIdWrite;
  logic        ifIdFlush;
  logic        idExBubble;
  logic [15:0] stallCnt;
  logic [15:0] flushCnt;

  int total = 0;
  int bad   = 0;

  // Reference state: only whether a redirect is owed and where it goes.
  bit          mPendValid = 1'b0;
  logic [31:0] mPendAddr  = '0;
  int          mStall     = 0;
  int          mFlush     = 0;

  always #5 clk = ~clk;

  pc_control #(.ADDR_W(32), .CNT_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .imemReady    (imemReady),
    .pcPlus4      (pcPlus4),
    .branchTaken  (branchTaken),
    .branchTarget (branchTarget),
    .jump         (jump),
    .jumpTarget   (jumpTarget),
    .idExMemRead  (idExMemRead),
    .idExRt       (idExRt),
    .ifIdRs       (ifIdRs),
    .ifIdRt       (ifIdRt),
    .pcWrite      (pcWrite),
    .pcNext       (pcNext),
    .ifIdWrite    (ifIdWrite),
    .ifIdFlush    (ifIdFlush),
    .idExBubble   (idExBubble),
    .stallCnt     (stallCnt),
    .flushCnt     (flushCnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s observed=%h expected=%h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic applyStimulus(input bit rst, input bit rdy, input logic [31:0] p4,
                               input bit br, input logic [31:0] bt,
                               input bit jp, input logic [31:0] jt,
                               input bit mr, input logic [4:0] ert,
                               input logic [4:0] rs, input logic [4:0] rt);
    reset = rst; imemReady = rdy; pcPlus4 = p4;
    branchTaken = br; branchTarget = bt; jump = jp; jumpTarget = jt;
    idExMemRead = mr; idExRt = ert; ifIdRs = rs; ifIdRt = rt;
  endtask

  // Called #1 after an edge: checks the combinational outputs for the current
  // inputs, crosses the next edge and advances the model, then checks counters.
  task automatic checkOutput(input bit doCheck);
    logic        eWr, eIfIdWr, eFlush, eBubble;
    logic [31:0] eNext, tgt;
    bit          hz, rd, loadsTarget, stalls;
    #3;
    hz  = idExMemRead && (idExRt != 0) && (idExRt == ifIdRs || idExRt == ifIdRt);
    rd  = !hz && (jump || branchTaken);
    tgt = jump ? jumpTarget : branchTarget;
    eWr = 0; eNext = pcPlus4; eIfIdWr = 1; eFlush = 0; eBubble = 0;
    loadsTarget = 0;
    if (!reset) begin
      eIfIdWr = 0; eFlush = 1; eBubble = 1;
    end else if (hz) begin
      eIfIdWr = 0; eBubble = 1;
    end else if (mPendValid) begin
      eFlush = 1;
      if (imemReady) begin eWr = 1; eNext = mPendAddr; loadsTarget = 1; end
    end else if (imemReady) begin
      eWr = 1;
      if (rd) begin eNext = tgt; eFlush = 1; loadsTarget = 1; end
    end else begin
      eFlush = 1;
    end
    stalls = hz || !eWr;
    if (doCheck) begin
      check("pcWrite",    {31'b0, pcWrite},    {31'b0, eWr});
      check("pcNext",     pcNext,              eNext);
      check("ifIdWrite",  {31'b0, ifIdWrite},  {31'b0, eIfIdWr});
      check("ifIdFlush",  {31'b0, ifIdFlush},  {31'b0, eFlush});
      check("idExBubble", {31'b0, idExBubble}, {31'b0, eBubble});
    end
    @(posedge clk);
    #1;
    if (!reset) begin
      mPendValid = 0; mPendAddr = '0; mStall = 0; mFlush = 0;
    end else begin
      if (!hz && mPendValid && imemReady) mPendValid = 0;
      else if (!hz && !mPendValid && !imemReady && rd) begin
        mPendValid = 1; mPendAddr = tgt;
      end
      if (stalls && mStall < 65535) mStall++;
      if (loadsTarget && mFlush < 65535) mFlush++;
    end
    if (doCheck) begin
      check("stallCnt", {16'b0, stallCnt}, mStall[31:0]);
      check("flushCnt", {16'b0, flushCnt}, mFlush[31:0]);
    end
  endtask

  initial begin
    // Reset, then plain sequential fetch.
    applyStimulus(0, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);
    applyStimulus(1, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // Load-use hazard, then same pattern with the load targeting r0.
    applyStimulus(1, 1, 32'h8, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd1);
    checkOutput(1);
    applyStimulus(1, 1, 32'h8, 0, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0);
    checkOutput(1);

    // Taken branch, then branch and jump together (jump wins).
    applyStimulus(1, 1, 32'hC, 1, 32'h40, 0, 0, 0, 0, 0, 0);
    checkOutput(1);
    applyStimulus(1, 1, 32'h44, 1, 32'h40, 1, 32'h80, 0, 0, 0, 0);
    checkOutput(1);

    // Redirect while imem is slow: deferred for three cycles, replayed on ready.
    applyStimulus(1, 0, 32'h84, 1, 32'h100, 0, 0, 0, 0, 0, 0);
    checkOutput(1);
    applyStimulus(1, 0, 32'h84, 1, 32'h200, 0, 0, 0, 0, 0, 0);
    checkOutput(1);
    checkOutput(1);
    applyStimulus(1, 1, 32'h84, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);
    applyStimulus(1, 1, 32'h104, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // Hazard beats a taken branch; the branch lands once the hazard clears.
    applyStimulus(1, 1, 32'h108, 1, 32'h300, 0, 0, 1, 5'd7, 5'd2, 5'd7);
    checkOutput(1);
    applyStimulus(1, 1, 32'h108, 1, 32'h300, 0, 0, 0, 5'd7, 5'd2, 5'd7);
    checkOutput(1);

    // Reset while a deferred redirect is pending discards it.
    applyStimulus(1, 0, 32'h304, 0, 0, 1, 32'h500, 0, 0, 0, 0);
    checkOutput(1);
    applyStimulus(0, 0, 32'h304, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);
    applyStimulus(1, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);

    // Random traffic with small register indices so hazards are frequent.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(($urandom_range(0, 49) != 0), ($urandom_range(0, 3) != 0),
                    $urandom, ($urandom_range(0, 3) == 0), $urandom,
                    ($urandom_range(0, 5) == 0), $urandom,
                    $urandom_range(0, 1), 5'($urandom_range(0, 3)),
                    5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      checkOutput(1);
    end

    // Drive stallCnt into saturation and confirm it holds at all-ones.
    applyStimulus(0, 1, 32'h4, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput(1);
    applyStimulus(1, 1, 32'h4, 0, 0, 0, 0, 1, 5'd5, 5'd5, 5'd0);
    for (int i = 0; i < 65540; i++) checkOutput(0);
    checkOutput(1);
    check("stallCntSat", {16'b0, stallCnt}, 32'h0000_FFFF);
    checkOutput(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pc_control.md
Name: pc_control

Overview:
- Sequencing controller for the pipeline CPU's program counter register and the IF/ID boundary.
- Decides each cycle whether the PC loads, and from which source: sequential, branch/jump target, or a deferred redirect.
- Detects load-use hazards and tolerates a slow instruction memory (imemReady handshake). A redirect that arrives while fetch is stalled is held and replayed.
- Drives pcWrite/pcNext into the PC register and write/flush/bubble controls into the IF/ID and ID/EX registers. Also keeps saturating performance counters.

Parameters:
- ADDR_W, 32, PC/address width.
- CNT_W, 16, width of each saturating perf counter.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-low; 0 at a clk edge resets state.
- imemReady  in  1  instruction memory returned the word for the current PC this cycle.
- pcPlus4  in  ADDR_W  current PC + 4.
- branchTaken  in  1  branch in ID resolved taken.
- branchTarget  in  ADDR_W  branch target from ID.
- jump  in  1  jump in ID.
- jumpTarget  in  ADDR_W  jump target from ID.
- idExMemRead  in  1  instruction in EX is a load.
- idExRt  in  5  destination register of that load.
- ifIdRs, ifIdRt  in  5 each  source registers of the instruction in ID.
- pcWrite  out  1  PC register load enable.
- pcNext  out  ADDR_W  value to load into the PC.
- ifIdWrite  out  1  IF/ID load enable.
- ifIdFlush  out  1  load a NOP into IF/ID.
- idExBubble  out  1  zero ID/EX control fields.
- stallCnt  out  CNT_W  load-use plus memory-wait stall cycles, saturating.
- flushCnt  out  CNT_W  redirects taken, saturating.

Behaviour:
- State: FSM {RUN, WAIT, WAIT_REDIR}, pendTarget[ADDR_W], and the two counters. All update only at posedge clk.
- Control outputs are combinational from state and inputs, acting in the same cycle. The PC register loads at the next edge.
- hazard = idExMemRead && idExRt != 0 && (idExRt == ifIdRs || idExRt == ifIdRt).
- redir = !hazard && (jump || branchTaken).
- redirTarget = jump ? jumpTarget : branchTarget. Jump wins if both are asserted.
- Defaults: pcWrite=0, pcNext=pcPlus4, ifIdWrite=1, ifIdFlush=0, idExBubble=0.
- Priority 1, hazard (any state):
  - idExBubble=1, ifIdWrite=0, pcWrite=0.
  - Any branch/jump in ID is ignored this cycle and re-evaluated next cycle.
  - State is unchanged, except RUN with !imemReady moves to WAIT.
- RUN, not hazard:
  - imemReady && redir: pcWrite=1, pcNext=redirTarget, ifIdFlush=1; stay in RUN.
  - imemReady && !redir: pcWrite=1, pcNext=pcPlus4; stay in RUN.
  - !imemReady && redir: pcWrite=0, ifIdFlush=1, pendTarget<=redirTarget; go to WAIT_REDIR.
  - !imemReady && !redir: pcWrite=0, ifIdFlush=1; go to WAIT.
- WAIT, not hazard:
  - Behaves as RUN, with the same four cases.
  - Any ready cycle returns to RUN.
- WAIT_REDIR, not hazard:
  - New redir inputs are ignored; the pending redirect is already committed and ID holds a bubble.
  - !imemReady: pcWrite=0, ifIdFlush=1; stay in WAIT_REDIR.
  - imemReady: pcWrite=1, pcNext=pendTarget, ifIdFlush=1 (the word fetched is wrong-path); go to RUN.
- Counters:
  - stallCnt += 1 on any cycle with hazard or pcWrite==0.
  - flushCnt += 1 on each cycle where a redirect is loaded into the PC (pcWrite && pcNext came from a target).
  - Both saturate at all-ones; no wrap.
- Reset (reset==0 at an edge), including mid-WAIT_REDIR:
  - State=RUN, pendTarget=0, stallCnt=0, flushCnt=0.
  - During the reset cycle outputs are forced to pcWrite=0, ifIdWrite=0, ifIdFlush=1, idExBubble=1.
  - The PC register's own reset supplies PC=0.
- Latency: a redirect with imemReady=1 reaches the PC at the next edge, giving a one-cycle flush penalty. A deferred redirect reaches the PC at the first edge after imemReady=1.

Decomposition:
- Shared package (pipe_pkg):
  - State encoding enum: RUN=2'd0, WAIT=2'd1, WAIT_REDIR=2'd2.
  - REG_ZERO=5'd0.
  - NOP encoding used by the flush logic.
- One natural sub-module: sat_counter (CNT_W, enable, synchronous active-low clear), instantiated twice.
- Hazard compare stays inline.

Test Plan:
- Reset then run with imemReady=1 and pcPlus4=0x4: expect pcWrite=1, pcNext=0x4, outputs 0 flush/bubble; stallCnt=0, flushCnt=0.
- idExMemRead=1, idExRt=5, ifIdRs=5: expect pcWrite=0, ifIdWrite=0, idExBubble=1 for exactly that cycle; stallCnt=1. Repeating with idExRt=0 must produce no stall.
- branchTaken=1, branchTarget=0x40, imemReady=1: expect pcNext=0x40, pcWrite=1, ifIdFlush=1, flushCnt=1. Adding jump=1 with jumpTarget=0x80 must give pcNext=0x80.
- branchTaken=1, target 0x100, imemReady=0 for 3 cycles then 1: state goes WAIT_REDIR; pcWrite=0 and ifIdFlush=1 for 3 cycles; on the ready cycle pcNext=0x100, pcWrite=1; state returns to RUN.
- Hazard and branchTaken together: stall wins with no redirect that cycle. Next cycle, with the hazard cleared, the redirect is applied.
- Drive reset=0 while in WAIT_REDIR: next state RUN, pendTarget=0, counters 0. Then force stallCnt to saturate at 0xFFFF and check it holds.
